// File: rtl/touch_slavemod_if.sv
// ---------------------------------------------------------------------------
// touch_slavemod_if : four-wire serial link between touch-panel master and ADC slave
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface touch_slavemod_if;
    logic TP_CS_N;
    logic TP_CLK;
    logic TP_DI;
    logic TP_DO;

    modport master (
        output TP_CS_N,
        output TP_CLK,
        output TP_DI,
        input  TP_DO
    );

    modport slave (
        input  TP_CS_N,
        input  TP_CLK,
        input  TP_DI,
        output TP_DO
    );
endinterface

`default_nettype wire

// File: rtl/touch_slavemod.sv
// ---------------------------------------------------------------------------
// touch_slavemod : emulates a 12-bit touch-panel ADC answering X/Y commands
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module touch_slavemod #(
    parameter logic [11:0] DEF_DATA = 12'h000
) (
    input  wire logic        CLOCK,
    input  wire logic        RESET,
    touch_slavemod_if.slave  tp,
    input  wire logic [11:0] iXData,
    input  wire logic [11:0] iYData,
    output logic             oBusy,
    output logic [7:0]       oCmd,
    output logic             oDone,
    output logic             oErr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_BUSY = 3'd2,
        S_READ = 3'd3,
        S_TAIL = 3'd4
    } state_t;

    logic [1:0]  cs_sync_q, clk_sync_q, di_sync_q;
    logic        cs_prev_q, clk_prev_q;

    state_t      state_q,  state_d;
    logic [4:0]  rcnt_q,   rcnt_d;
    logic [7:0]  cmd_sr_q, cmd_sr_d;
    logic [11:0] sr_q,     sr_d;
    logic        do_q,     do_d;
    logic        busy_q,   busy_d;
    logic [7:0]  cmd_q,    cmd_d;
    logic        inv_q,    inv_d;
    logic        done_q,   done_d;
    logic        err_q,    err_d;

    logic        cs_fall, cs_rise, sclk_fall, sclk_rise;
    logic        cs_low;
    logic [7:0]  cmd_shift;
    logic [4:0]  rcnt_inc;

    assign cs_fall   =  cs_prev_q  & ~cs_sync_q[1];
    assign cs_rise   = ~cs_prev_q  &  cs_sync_q[1];
    assign sclk_fall =  clk_prev_q & ~clk_sync_q[1];
    assign sclk_rise = ~clk_prev_q &  clk_sync_q[1];
    assign cs_low    = ~cs_sync_q[1];
    assign cmd_shift = {cmd_sr_q[6:0], di_sync_q[1]};
    // Extra clocks after the data word must not wrap the edge counter
    assign rcnt_inc  = (rcnt_q == 5'd31) ? 5'd31 : rcnt_q + 5'd1;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cs_sync_q  <= 2'b11;
            clk_sync_q <= 2'b11;
            di_sync_q  <= 2'b00;
            cs_prev_q  <= 1'b1;
            clk_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            rcnt_q     <= 5'd0;
            cmd_sr_q   <= 8'h00;
            sr_q       <= 12'h000;
            do_q       <= 1'b0;
            busy_q     <= 1'b0;
            cmd_q      <= 8'h00;
            inv_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[0],  tp.TP_CS_N};
            clk_sync_q <= {clk_sync_q[0], tp.TP_CLK};
            di_sync_q  <= {di_sync_q[0],  tp.TP_DI};
            cs_prev_q  <= cs_sync_q[1];
            clk_prev_q <= clk_sync_q[1];
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            cmd_sr_q   <= cmd_sr_d;
            sr_q       <= sr_d;
            do_q       <= do_d;
            busy_q     <= busy_d;
            cmd_q      <= cmd_d;
            inv_q      <= inv_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        cmd_sr_d = cmd_sr_q;
        sr_d     = sr_q;
        do_d     = do_q;
        busy_d   = busy_q;
        cmd_d    = cmd_q;
        inv_d    = inv_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (cs_rise) begin
            state_d = S_IDLE;
            do_d    = 1'b0;
            busy_d  = 1'b0;
            case (state_q)
                S_TAIL: begin
                    done_d = ~inv_q;
                    err_d  =  inv_q;
                end
                S_CMD, S_BUSY, S_READ: err_d = 1'b1;
                default: ;
            endcase
        end else if (cs_fall) begin
            // Frame start outranks any SCLK edge seen in the same cycle
            if (state_q == S_IDLE) begin
                state_d  = S_CMD;
                rcnt_d   = 5'd0;
                cmd_sr_d = 8'h00;
                do_d     = 1'b0;
                inv_d    = 1'b0;
            end
        end else if (cs_low) begin
            case (state_q)
                S_CMD: begin
                    if (sclk_rise) begin
                        cmd_sr_d = cmd_shift;
                        rcnt_d   = rcnt_inc;
                        if (rcnt_q == 5'd7) begin
                            state_d = S_BUSY;
                            cmd_d   = cmd_shift;
                            inv_d   = ~cmd_shift[7];
                            if (!cmd_shift[7]) begin
                                sr_d = 12'h000;
                            end else begin
                                case (cmd_shift[6:4])
                                    3'b001:  sr_d = iXData;
                                    3'b101:  sr_d = iYData;
                                    default: sr_d = DEF_DATA;
                                endcase
                            end
                        end
                    end
                end
                S_BUSY: begin
                    if (sclk_rise) begin
                        rcnt_d = rcnt_inc;
                    end else if (sclk_fall) begin
                        if (rcnt_q == 5'd8) begin
                            busy_d = 1'b1;
                        end else if (rcnt_q == 5'd9) begin
                            busy_d  = 1'b0;
                            state_d = S_READ;
                            do_d    = sr_q[11];
                            sr_d    = {sr_q[10:0], 1'b0};
                        end
                    end
                end
                S_READ: begin
                    if (sclk_rise) begin
                        rcnt_d = rcnt_inc;
                        if (rcnt_q == 5'd20) begin
                            state_d = S_TAIL;
                        end
                    end else if (sclk_fall) begin
                        do_d = sr_q[11];
                        sr_d = {sr_q[10:0], 1'b0};
                    end
                end
                S_TAIL: begin
                    if (sclk_rise) begin
                        rcnt_d = rcnt_inc;
                    end else if (sclk_fall) begin
                        do_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tp.TP_DO = do_q;
    assign oBusy    = busy_q;
    assign oCmd     = cmd_q;
    assign oDone    = done_q;
    assign oErr     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_touch_slavemod.sv
// ---------------------------------------------------------------------------
// tb_touch_slavemod : directed frames against a cycle-level protocol model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_touch_slavemod;

    localparam int          H   = 10;
    localparam logic [11:0] DEF = 12'h000;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic [11:0] iXData = 12'h000;
    logic [11:0] iYData = 12'h000;
    logic        oBusy;
    logic [7:0]  oCmd;
    logic        oDone;
    logic        oErr;

    int n_pass   = 0;
    int n_total  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    touch_slavemod_if tp();

    touch_slavemod #(.DEF_DATA(DEF)) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .tp     (tp),
        .iXData (iXData),
        .iYData (iYData),
        .oBusy  (oBusy),
        .oCmd   (oCmd),
        .oDone  (oDone),
        .oErr   (oErr)
    );

    always #10 CLOCK = ~CLOCK;

    typedef struct packed {
        logic       do_b;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] cmd;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    function automatic logic [11:0] expected_word(input logic [7:0] c, input logic [11:0] x,
                                                  input logic [11:0] y);
        if (!c[7])               return 12'h000;
        else if (c[6:4] == 3'd1) return x;
        else if (c[6:4] == 3'd5) return y;
        else                     return DEF;
    endfunction

    // Protocol model: tracks pin-level edges, predicts outputs two samples later
    initial begin : compare
        exp_t        e_now, p0, p1;
        logic        pcs, pclk, m_valid;
        bit          in_frame;
        int          falls, rises;
        logic [7:0]  m_cmd_sr, m_ocmd;
        logic [11:0] m_data;
        pcs = 1'b1; pclk = 1'b1; m_valid = 1'b0; in_frame = 0;
        falls = 0; rises = 0; m_cmd_sr = 8'h00; m_ocmd = 8'h00; m_data = 12'h000;
        p0 = '0; p1 = '0;
        forever begin
            @(posedge CLOCK);
            #1;
            e_now = '0;
            if (!RESET) begin
                in_frame = 0; falls = 0; rises = 0; m_ocmd = 8'h00;
                p0 = '0; p1 = '0;
            end else if (pcs && !tp.TP_CS_N) begin
                in_frame = 1; falls = 0; rises = 0; m_cmd_sr = 8'h00; m_valid = 1'b0;
            end else if (!pcs && tp.TP_CS_N) begin
                if (in_frame) begin
                    if (rises >= 21 && m_valid) e_now.done = 1'b1;
                    else                        e_now.err  = 1'b1;
                end
                in_frame = 0;
            end else if (in_frame) begin
                if (pclk && !tp.TP_CLK) falls++;
                if (!pclk && tp.TP_CLK) begin
                    rises++;
                    if (rises <= 8) m_cmd_sr = {m_cmd_sr[6:0], tp.TP_DI};
                    if (rises == 8) begin
                        m_ocmd  = m_cmd_sr;
                        m_valid = m_cmd_sr[7];
                        m_data  = expected_word(m_cmd_sr, iXData, iYData);
                    end
                end
            end
            pcs  = tp.TP_CS_N;
            pclk = tp.TP_CLK;
            e_now.busy = in_frame && (falls == 9);
            e_now.do_b = (in_frame && falls >= 10 && falls <= 21) ? m_data[21-falls] : 1'b0;
            e_now.cmd  = m_ocmd;

            chk("cyc_TP_DO", 32'(tp.TP_DO), 32'(p1.do_b));
            chk("cyc_oBusy", 32'(oBusy),    32'(p1.busy));
            chk("cyc_oDone", 32'(oDone),    32'(p1.done));
            chk("cyc_oErr",  32'(oErr),     32'(p1.err));
            chk("cyc_oCmd",  32'(oCmd),     32'(p1.cmd));
            if (oDone) done_cnt++;
            if (oErr)  err_cnt++;
            p1 = p0;
            p0 = e_now;
        end
    end

    task automatic frame(input logic [7:0] cmd, input int nclk, input int rst_fall,
                         input int chg_fall, output logic [11:0] word);
        word = 12'h000;
        @(negedge CLOCK);
        tp.TP_CS_N = 1'b0;
        wait_cyc(H);
        for (int k = 1; k <= nclk; k++) begin
            tp.TP_CLK = 1'b0;
            tp.TP_DI  = (k <= 8) ? cmd[8-k] : 1'b0;
            if (k == chg_fall) iYData = 12'hFFF;
            if (k == rst_fall) begin
                wait_cyc(3);
                chk("busy_before_reset", 32'(oBusy), 32'(1));
                RESET = 1'b0;
                wait_cyc(1);
                chk("rst_TP_DO", 32'(tp.TP_DO), 32'(0));
                chk("rst_oBusy", 32'(oBusy),    32'(0));
                chk("rst_oCmd",  32'(oCmd),     32'(0));
                tp.TP_CS_N = 1'b1;
                tp.TP_CLK  = 1'b1;
                tp.TP_DI   = 1'b0;
                wait_cyc(3);
                RESET = 1'b1;
                wait_cyc(6);
                return;
            end
            wait_cyc(H);
            if (k >= 10 && k <= 21) word = {word[10:0], tp.TP_DO};
            tp.TP_CLK = 1'b1;
            wait_cyc(H);
        end
        if (nclk > 21) chk("tail_TP_DO", 32'(tp.TP_DO), 32'(0));
        tp.TP_CS_N = 1'b1;
        wait_cyc(4);
        chk("after_cs_TP_DO", 32'(tp.TP_DO), 32'(0));
        chk("after_cs_oBusy", 32'(oBusy),    32'(0));
        wait_cyc(6);
    endtask

    task automatic run(input string name, input logic [7:0] cmd, input int nclk,
                       input int rst_fall, input int chg_fall, input logic [11:0] exp_word,
                       input logic [7:0] exp_cmd, input int exp_done, input int exp_err);
        int          d0, e0;
        logic [11:0] word;
        d0 = done_cnt;
        e0 = err_cnt;
        frame(cmd, nclk, rst_fall, chg_fall, word);
        if (nclk >= 21 && rst_fall == 0) chk({name, "_word"}, 32'(word), 32'(exp_word));
        chk({name, "_oCmd"}, 32'(oCmd), 32'(exp_cmd));
        chk({name, "_done"}, 32'(done_cnt - d0), 32'(exp_done));
        chk({name, "_err"},  32'(err_cnt - e0),  32'(exp_err));
    endtask

    initial begin : stim
        tp.TP_CS_N = 1'b1;
        tp.TP_CLK  = 1'b1;
        tp.TP_DI   = 1'b0;
        RESET      = 1'b0;
        wait_cyc(5);
        chk("reset_TP_DO", 32'(tp.TP_DO), 32'(0));
        chk("reset_oBusy", 32'(oBusy),    32'(0));
        chk("reset_oCmd",  32'(oCmd),     32'(0));
        chk("reset_oDone", 32'(oDone),    32'(0));
        chk("reset_oErr",  32'(oErr),     32'(0));
        RESET = 1'b1;
        wait_cyc(5);

        // SCLK activity with CS high must not disturb anything
        for (int i = 0; i < 6; i++) begin
            tp.TP_CLK = ~tp.TP_CLK;
            wait_cyc(H);
        end
        tp.TP_CLK = 1'b1;
        wait_cyc(H);

        iXData = 12'hABC;
        run("x_abc",     8'h90, 24, 0, 0,  12'hABC, 8'h90, 1, 0);
        iYData = 12'h35A;
        run("y_snap",    8'hD0, 24, 0, 12, 12'h35A, 8'hD0, 1, 0);
        run("def_chan",  8'hA0, 24, 0, 0,  12'h000, 8'hA0, 1, 0);
        run("no_start",  8'h10, 24, 0, 0,  12'h000, 8'h10, 0, 1);
        run("min_clks",  8'h90, 21, 0, 0,  12'hABC, 8'h90, 1, 0);
        iXData = 12'h5A3;
        run("abort_rd",  8'h90, 15, 0, 0,  12'h000, 8'h90, 0, 1);
        run("after_ab",  8'h90, 24, 0, 0,  12'h5A3, 8'h90, 1, 0);
        run("abort_cmd", 8'hD0, 4,  0, 0,  12'h000, 8'h90, 0, 1);
        run("rst_busy",  8'h90, 24, 9, 0,  12'h000, 8'h00, 0, 0);
        run("post_rst",  8'h90, 24, 0, 0,  12'h5A3, 8'h90, 1, 0);
        run("y_fff",     8'hD0, 24, 0, 0,  12'hFFF, 8'hD0, 1, 0);

        wait_cyc(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
